serial_cmd_processor: RTL and testbench

- Parametrised command processor between the UART byte receiver/transmitter and the trigger-board control fabric.
- Decodes one-byte opcodes with 0–2 argument bytes and maintains an addressable bank of 8-bit configuration registers plus 8 toggle flags.
- Drives PLL dynamic phase stepping and clock switching, and serialises a configurable number of histogram channels back to the host.
- Adds to the previous generation: register read-back, an inter-byte argument timeout, and an error counter.

---
 rtl/serial_cmd_pkg.sv | 42 ++++
 rtl/serial_cmd_processor_if.sv | 16 +
 rtl/serial_cmd_processor_phase_step.sv | 57 +++++
 rtl/serial_cmd_processor.sv | 250 +++++++++++++++++++++++++
 tb/tb_serial_cmd_processor.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the serial command processor: opcode values,
// FSM state encoding and the per-opcode argument count.
package serial_cmd_pkg;

    localparam logic [7:0] OP_VERSION = 8'h00;
    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_FLAG    = 8'h03;
    localparam logic [7:0] OP_SWITCH  = 8'h04;
    localparam logic [7:0] OP_PHASE   = 8'h05;
    localparam logic [7:0] OP_HIST    = 8'h06;
    localparam logic [7:0] OP_ERRCNT  = 8'h07;

    // Legacy state encodings; the enum below carries the same values.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARGS    = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_TX_LOAD = 3'd3;
    localparam logic [2:0] ST_TX_WAIT = 3'd4;
    localparam logic [2:0] ST_PHASE   = 3'd5;
    localparam logic [2:0] ST_SWITCH  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ARGS    = ST_ARGS,
        S_EXEC    = ST_EXEC,
        S_TX_LOAD = ST_TX_LOAD,
        S_TX_WAIT = ST_TX_WAIT,
        S_PHASE   = ST_PHASE,
        S_SWITCH  = ST_SWITCH
    } state_t;

    // Number of argument bytes following an opcode; unknown opcodes take none.
    function automatic logic [1:0] nargs(input logic [7:0] op);
        case (op)
            OP_WRITE:                   return 2'd2;
            OP_READ, OP_FLAG, OP_PHASE: return 2'd1;
            default:                    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/serial_cmd_processor_if.sv
// Byte-stream link between the UART receiver/transmitter and the command
// processor.
//   rx_ready/rx_data : received byte strobe and value
//   tx_busy          : transmitter busy
//   tx_start/tx_data : one-cycle send strobe and byte to send
// master = UART side, slave = command processor side.
interface serial_cmd_processor_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (output rx_ready, rx_data, tx_busy, input tx_start, tx_data);
    modport slave  (input rx_ready, rx_data, tx_busy, output tx_start, tx_data);
endinterface

// File: rtl/serial_cmd_processor_phase_step.sv
// PLL dynamic phase-step sequencer.
//   clk, reset  : system clock, asynchronous active-high reset
//   start_i     : one-cycle request; outputs take their entry values next cycle
//   scanclk_o   : toggles every PHASE_HALF cycles, 8 toggles per sequence
//   phasestep_o : high from entry until the 6th toggle
//   done_o      : high in the last cycle of the sequence
module phase_step_sequencer #(
    parameter int unsigned PHASE_HALF = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic scanclk_o,
    output logic phasestep_o,
    output logic done_o
);
    localparam int unsigned CW = (PHASE_HALF > 1) ? $clog2(PHASE_HALF) : 1;

    logic          active_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    tog_q;
    logic          scanclk_q;
    logic          step_q;
    logic          half_end;

    assign half_end    = active_q && (cnt_q == CW'(PHASE_HALF - 1));
    // Combinational so the main FSM leaves PHASE on the same edge as the 8th toggle.
    assign done_o      = half_end && (tog_q == 3'd7);
    assign scanclk_o   = scanclk_q;
    assign phasestep_o = step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            tog_q     <= '0;
            scanclk_q <= 1'b0;
            step_q    <= 1'b0;
        end else if (start_i) begin
            active_q  <= 1'b1;
            cnt_q     <= '0;
            tog_q     <= '0;
            scanclk_q <= 1'b0;
            step_q    <= 1'b1;
        end else if (active_q) begin
            if (half_end) begin
                cnt_q     <= '0;
                scanclk_q <= ~scanclk_q;
                tog_q     <= tog_q + 3'd1;
                if (tog_q == 3'd5) step_q   <= 1'b0;
                if (tog_q == 3'd7) active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/serial_cmd_processor.sv
// Serial command processor: decodes host opcodes from the UART, maintains a
// register bank and toggle flags, drives PLL phase stepping / clock switching
// and dumps histogram channels back to the host.
//   clk, reset          : system clock, asynchronous active-high reset
//   uart                : rx/tx byte handshake (slave modport)
//   hist                : NCHAN channels of HWIDTH bits, channel c at [c*HWIDTH +: HWIDTH]
//   hist_reset          : clear pulse, coincident with the dump decode cycle
//   regs, flags         : configuration registers (r at [r*8 +: 8]) and toggle flags
//   phasecounterselect, phaseupdown, phasestep, scanclk, clkswitch : PLL control
//   err_count           : saturating protocol-error count
module serial_cmd_processor
    import serial_cmd_pkg::*;
#(
    parameter int unsigned NCHAN      = 4,
    parameter int unsigned HWIDTH     = 32,
    parameter int unsigned NREGS      = 8,
    parameter logic [7:0]  FW_VERSION = 8'd10,
    parameter logic [7:0]  FLAG_INIT  = 8'h01,
    parameter int unsigned TIMEOUT    = 1_000_000,
    parameter int unsigned PHASE_HALF = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_cmd_processor_if.slave   uart,
    input  logic [NCHAN*HWIDTH-1:0] hist,
    output logic                    hist_reset,
    output logic [NREGS*8-1:0]      regs,
    output logic [7:0]              flags,
    output logic [2:0]              phasecounterselect,
    output logic                    phaseupdown,
    output logic                    phasestep,
    output logic                    scanclk,
    output logic                    clkswitch,
    output logic [7:0]              err_count
);
    localparam int unsigned NBITS  = NCHAN * HWIDTH;
    localparam int unsigned NBYTES = NBITS / 8;
    localparam int unsigned IW     = $clog2(NBYTES + 1);
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [7:0]       op_q, op_d, arg0_q, arg0_d, arg1_q, arg1_d;
    logic             arg_idx_q, arg_idx_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [NBITS-1:0] buf_q, buf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       regs_q [NREGS];
    logic [7:0]       regs_d [NREGS];
    logic [7:0]       flags_q, flags_d, err_q, err_d;
    logic [2:0]       pcs_q, pcs_d, swcnt_q, swcnt_d;
    logic             pud_q, pud_d, sw_q, sw_d;
    logic             ph_start, ph_done, err_inc, one_byte, addr_ok;
    logic [7:0]       one_val, rd_byte;

    phase_step_sequencer #(.PHASE_HALF(PHASE_HALF)) u_phase (
        .clk         (clk),
        .reset       (reset),
        .start_i     (ph_start),
        .scanclk_o   (scanclk),
        .phasestep_o (phasestep),
        .done_o      (ph_done)
    );

    assign addr_ok            = (32'(arg0_q) < NREGS);
    assign hist_reset         = (state_q == S_EXEC) && (op_q == OP_HIST);
    assign uart.tx_start      = tx_start_q;
    assign uart.tx_data       = tx_data_q;
    assign flags              = flags_q;
    assign err_count          = err_q;
    assign phasecounterselect = pcs_q;
    assign phaseupdown        = pud_q;
    assign clkswitch          = sw_q;

    always_comb begin
        rd_byte = '0;
        regs    = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (arg0_q == 8'(r)) rd_byte = regs_q[r];
            regs[r*8 +: 8] = regs_q[r];
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        arg0_d     = arg0_q;
        arg1_d     = arg1_q;
        arg_idx_d  = arg_idx_q;
        tmr_d      = tmr_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        regs_d     = regs_q;
        flags_d    = flags_q;
        err_d      = err_q;
        pcs_d      = pcs_q;
        pud_d      = pud_q;
        sw_d       = sw_q;
        swcnt_d    = swcnt_q;
        ph_start   = 1'b0;
        err_inc    = 1'b0;
        one_byte   = 1'b0;
        one_val    = '0;

        case (state_q)
            S_IDLE: if (uart.rx_ready) begin
                op_d      = uart.rx_data;
                arg_idx_d = 1'b0;
                tmr_d     = '0;
                state_d   = (nargs(uart.rx_data) == 2'd0) ? S_EXEC : S_ARGS;
            end
            S_ARGS: begin
                if (uart.rx_ready) begin
                    tmr_d     = '0;
                    arg_idx_d = 1'b1;
                    if (!arg_idx_q) arg0_d = uart.rx_data;
                    else            arg1_d = uart.rx_data;
                    if ({1'b0, arg_idx_q} + 2'd1 == nargs(op_q)) state_d = S_EXEC;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_VERSION: begin
                        one_byte = 1'b1;
                        one_val  = FW_VERSION;
                    end
                    OP_WRITE: begin
                        if (addr_ok) begin
                            for (int unsigned r = 0; r < NREGS; r++)
                                if (arg0_q == 8'(r)) regs_d[r] = arg1_q;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                    OP_READ: begin
                        one_byte = 1'b1;
                        one_val  = rd_byte;
                        err_inc  = !addr_ok;
                    end
                    OP_FLAG: flags_d[arg0_q[2:0]] = ~flags_q[arg0_q[2:0]];
                    OP_SWITCH: begin
                        sw_d    = 1'b1;
                        swcnt_d = '0;
                        state_d = S_SWITCH;
                    end
                    OP_PHASE: begin
                        pcs_d    = arg0_q[2:0];
                        pud_d    = arg0_q[3];
                        ph_start = 1'b1;
                        state_d  = S_PHASE;
                    end
                    OP_HIST: begin
                        buf_d     = hist;
                        idx_d     = IW'(NBYTES);
                        tx_data_d = hist[7:0];
                        state_d   = S_TX_LOAD;
                    end
                    OP_ERRCNT: begin
                        one_byte = 1'b1;
                        one_val  = err_q;
                    end
                    default: err_inc = 1'b1;
                endcase
                // Single-byte replies reuse the dump buffer with a length of one.
                if (one_byte) begin
                    buf_d       = '0;
                    buf_d[7:0]  = one_val;
                    idx_d       = IW'(1);
                    tx_data_d   = one_val;
                    state_d     = S_TX_LOAD;
                end
            end
            S_TX_LOAD: if (!uart.tx_busy) begin
                tx_start_d = 1'b1;
                buf_d      = buf_q >> 8;
                idx_d      = idx_q - 1'b1;
                state_d    = S_TX_WAIT;
            end
            // tx_data changes only here, so it is stable through the next TX_LOAD and its strobe.
            S_TX_WAIT: begin
                if (idx_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tx_data_d = buf_q[7:0];
                    state_d   = S_TX_LOAD;
                end
            end
            S_PHASE: if (ph_done) state_d = S_IDLE;
            S_SWITCH: begin
                swcnt_d = swcnt_q + 3'd1;
                if (swcnt_q == 3'd7) begin
                    sw_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            arg0_q     <= '0;
            arg1_q     <= '0;
            arg_idx_q  <= 1'b0;
            tmr_q      <= '0;
            buf_q      <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            regs_q     <= '{default: '0};
            flags_q    <= FLAG_INIT;
            err_q      <= '0;
            pcs_q      <= '0;
            pud_q      <= 1'b1;
            sw_q       <= 1'b0;
            swcnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            arg0_q     <= arg0_d;
            arg1_q     <= arg1_d;
            arg_idx_q  <= arg_idx_d;
            tmr_q      <= tmr_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            regs_q     <= regs_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
            pcs_q      <= pcs_d;
            pud_q      <= pud_d;
            sw_q       <= sw_d;
            swcnt_q    <= swcnt_d;
        end
    end
endmodule

// File: tb/tb_serial_cmd_processor.sv
// Bench for serial_cmd_processor: directed commands, expected reply bytes
// queued by the stimulus and checked by an independent tx monitor.
module tb_serial_cmd_processor;
    localparam int unsigned TMO = 40;
    localparam int unsigned PH  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] hist;
    logic         hist_reset;
    logic [63:0]  regs;
    logic [7:0]   flags, err_count;
    logic [2:0]   pcs;
    logic         pud, phasestep, scanclk, clkswitch;

    serial_cmd_processor_if bus ();

    serial_cmd_processor #(.TIMEOUT(TMO), .PHASE_HALF(PH)) dut (
        .clk                (clk),
        .reset              (reset),
        .uart               (bus),
        .hist               (hist),
        .hist_reset         (hist_reset),
        .regs               (regs),
        .flags              (flags),
        .phasecounterselect (pcs),
        .phaseupdown        (pud),
        .phasestep          (phasestep),
        .scanclk            (scanclk),
        .clkswitch          (clkswitch),
        .err_count          (err_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         pushed = 0;
    int         tx_count = 0;
    int         hr_cnt = 0;
    bit         hold = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        pushed++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // UART transmitter model: busy for 3 cycles after each strobe, or while held.
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.tx_start) busy_cnt = 3;
            else if (busy_cnt > 0) busy_cnt--;
            bus.tx_busy = hold || (busy_cnt > 0);
        end
    end

    // Monitor: compares every launched byte against the scoreboard queue.
    initial begin
        logic       prev_start, prev_busy;
        logic [7:0] prev_data;
        prev_start = 1'b0;
        prev_busy  = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (hist_reset) hr_cnt++;
            if (bus.tx_start === 1'b1) begin
                tx_count++;
                check("tx_start_single_cycle", 64'(prev_start), 64'd0);
                check("tx_launch_while_busy", 64'(prev_busy), 64'd0);
                check("tx_data_stable", 64'(bus.tx_data), 64'(prev_data));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h expected no byte", bus.tx_data);
                end else begin
                    check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
                end
            end
            prev_start = bus.tx_start;
            prev_busy  = bus.tx_busy;
            prev_data  = bus.tx_data;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, hi, step_hi, sc_hi, sc_rise, base;
        logic prev_sc;
        reset = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = '0;
        hist = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {31'd0, bus.tx_start, bus.tx_data, hist_reset, flags, pcs, pud, phasestep, scanclk, clkswitch, err_count},
              {31'd0, 1'b0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        check("reset_regs", regs, 64'h0);

        // Version
        send_byte(8'h00); expect_byte(8'h0A);
        drain("version_drain");

        // Write then read back
        send_byte(8'h01); send_byte(8'h03); send_byte(8'h5A);
        repeat (3) @(negedge clk);
        check("write_reg3", regs, 64'h0000_0000_5A00_0000);
        send_byte(8'h02); send_byte(8'h03); expect_byte(8'h5A);
        drain("read_drain");

        // Out-of-range accesses, unknown opcode, error counter read-back
        send_byte(8'h01); send_byte(8'h09); send_byte(8'hFF);
        repeat (3) @(negedge clk);
        check("oob_write_regs", regs, 64'h0000_0000_5A00_0000);
        send_byte(8'h07); expect_byte(8'h01);
        drain("errcnt1_drain");
        send_byte(8'h02); send_byte(8'h09); expect_byte(8'h00);
        drain("oob_read_drain");
        send_byte(8'h3C);
        send_byte(8'h07); expect_byte(8'h03);
        drain("errcnt3_drain");
        check("err_count_3", 64'(err_count), 64'd3);

        // Flags: update visible the cycle after EXEC
        send_byte(8'h03); send_byte(8'h05);
        @(negedge clk);
        check("flag_exec_cycle", 64'(flags), 64'h01);
        @(negedge clk);
        check("flag_set5", 64'(flags), 64'h21);
        send_byte(8'h03); send_byte(8'h08);
        repeat (2) @(negedge clk);
        check("flag_clear0", 64'(flags), 64'h20);

        // Histogram dump with a long busy stall mid-stream
        base = tx_count;
        hr_cnt = 0;
        send_byte(8'h06);
        for (int b = 1; b <= 16; b++) expect_byte(8'(b));
        for (int i = 0; i < 500 && tx_count < base + 5; i++) @(negedge clk);
        hold = 1'b1;
        repeat (100) @(posedge clk);
        hold = 1'b0;
        drain("hist_drain");
        check("hist_byte_count", 64'(tx_count - base), 64'd16);
        check("hist_reset_pulses", 64'(hr_cnt), 64'd1);

        // Clock switch: high exactly 8 cycles starting the cycle after EXEC
        send_byte(8'h04);
        first = -1; hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (clkswitch) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        check("clkswitch_rise", 64'(first), 64'd1);
        check("clkswitch_width", 64'(hi), 64'd8);

        // Phase step
        send_byte(8'h05); send_byte(8'h0B);
        step_hi = 0; sc_hi = 0; sc_rise = 0; prev_sc = 1'b0;
        for (int i = 0; i <= 8 * PH; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("phase_sel", {59'd0, pud, pcs, phasestep}, {59'd0, 1'b1, 3'd3, 1'b1});
                check("phase_entry_scanclk", 64'(scanclk), 64'd0);
            end
            if (phasestep) step_hi++;
            if (scanclk) sc_hi++;
            if (scanclk && !prev_sc) sc_rise++;
            prev_sc = scanclk;
        end
        // The first cycle after the sequence must already accept a command.
        send_byte(8'h00); expect_byte(8'h0A);
        check("phasestep_width", 64'(step_hi), 64'(6 * PH));
        check("scanclk_pulses", 64'(sc_rise), 64'd4);
        check("scanclk_high", 64'(sc_hi), 64'(4 * PH));
        check("phase_end_levels", {62'd0, scanclk, phasestep}, 64'd0);
        drain("phase_idle_drain");

        // Argument timer restarts per byte; a late-but-in-time byte completes
        send_byte(8'h01); send_byte(8'h02);
        repeat (TMO - 5) @(posedge clk);
        send_byte(8'h77);
        repeat (3) @(negedge clk);
        check("args_within_timeout", regs, 64'h0000_0000_5A77_0000);
        check("no_timeout_err", 64'(err_count), 64'd3);

        // Timeout discards the command
        send_byte(8'h01); send_byte(8'h02);
        repeat (TMO + 5) @(posedge clk);
        check("timeout_err", 64'(err_count), 64'd4);
        check("timeout_regs", regs, 64'h0000_0000_5A77_0000);
        send_byte(8'h00); expect_byte(8'h0A);
        drain("after_timeout_drain");

        // Reset in the middle of a phase sequence
        send_byte(8'h05); send_byte(8'h02);
        repeat (6) @(negedge clk);
        check("phase_running", 64'(phasestep), 64'd1);
        reset = 1'b1;
        #1;
        check("midreset_outputs",
              {40'd0, regs[7:0], flags, pcs, pud, phasestep, scanclk, clkswitch, err_count[0]},
              {40'd0, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("midreset_regs", regs, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h00); expect_byte(8'h0A);
        drain("after_reset_drain");

        check("total_tx_bytes", 64'(tx_count), 64'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
